// File: rtl/loop_controller.sv
// Loop controller: drives a downstream counter through `loops` passes of
// start_addr..end_addr (with wrap), then pulses done for one cycle.
module loop_controller #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] start_addr,
  input  logic [BUS_WIDTH-1:0] end_addr,
  input  logic [BUS_WIDTH-1:0] loops,
  input  logic [BUS_WIDTH-1:0] cnt,
  output logic                 st,
  output logic [BUS_WIDTH-1:0] X,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] remaining
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [BUS_WIDTH-1:0] ONE = BUS_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [BUS_WIDTH-1:0] start_q, start_d;
  logic [BUS_WIDTH-1:0] end_q,   end_d;
  logic [BUS_WIDTH-1:0] rem_q,   rem_d;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    end_d   = end_q;
    rem_d   = rem_q;
    st      = 1'b1;
    X       = cnt;
    // While in reset the counter is told to hold, whatever the state.
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_d = start_addr;
            end_d   = end_addr;
            rem_d   = loops;
            state_d = (loops != '0) ? S_LOAD : S_DONE;
          end
        end
        S_LOAD: begin
          X       = start_q;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (cnt != end_q) begin
            st = 1'b0;
          end else if (rem_q > ONE) begin
            X     = start_q;
            rem_d = rem_q - ONE;
          end else begin
            rem_d   = '0;
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= '0;
      end_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign remaining = rem_q;

endmodule

// File: tb/tb_loop_controller.sv
// Self-checking bench for loop_controller: expected per-cycle traces are
// built from the iteration arithmetic and compared on the falling edge.
module tb_loop_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_addr, end_addr, loops;
  logic [7:0] cnt;
  logic       st;
  logic [7:0] X;
  logic       busy, done;
  logic [7:0] remaining;

  logic       cnt_load;
  logic [7:0] cnt_val;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  model_cnt;

  typedef struct {
    bit         is_run;
    logic       busy;
    logic       done;
    logic [7:0] rem;
    logic [7:0] cnt;
    logic       st;
    logic [7:0] x;
  } exp_t;

  always #5 clk = ~clk;

  loop_controller #(.BUS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .start_addr(start_addr), .end_addr(end_addr), .loops(loops),
    .cnt(cnt), .st(st), .X(X), .busy(busy), .done(done),
    .remaining(remaining)
  );

  // Downstream counter: loads X when st, otherwise increments.
  always_ff @(posedge clk) begin
    if (cnt_load)  cnt <= cnt_val;
    else if (st)   cnt <= X;
    else           cnt <= cnt + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".st"},   32'(st),   32'd1);
    chk({tag, ".cnt"},  32'(cnt),  32'(model_cnt));
    chk({tag, ".X"},    32'(X),    32'(model_cnt));
  endtask

  // Starts a run from IDLE (called at a falling edge) and checks it cycle by
  // cycle through DONE and back into IDLE. With inject, start is re-asserted
  // with unrelated operands throughout RUN.
  task automatic do_run(input string tag, input logic [7:0] sa, input logic [7:0] ea,
                        input logic [7:0] lp, input bit inject);
    exp_t        q[$];
    exp_t        e;
    int unsigned len;
    logic [7:0]  fin;
    chk_idle({tag, ".pre"});
    chk({tag, ".pre.rem"}, 32'(remaining), 32'd0);
    start = 1'b1; start_addr = sa; end_addr = ea; loops = lp;
    @(negedge clk);
    start = 1'b0;
    len = 32'(8'(ea - sa)) + 1;
    fin = (lp == 0) ? model_cnt : ea;
    if (lp != 0) begin
      q.push_back('{0, 1'b1, 1'b0, lp, model_cnt, 1'b1, sa});
      for (int unsigned i = 0; i < lp; i++)
        for (int unsigned k = 0; k < len; k++) begin
          e = '{1, 1'b1, 1'b0, 8'(lp - i), 8'(sa + k), 1'b0, 8'h00};
          if (k == len - 1) begin
            e.st = 1'b1;
            e.x  = (i + 1 < lp) ? sa : ea;
          end
          q.push_back(e);
        end
    end
    q.push_back('{0, 1'b0, 1'b1, 8'd0, fin, 1'b1, fin});
    q.push_back('{0, 1'b0, 1'b0, 8'd0, fin, 1'b1, fin});
    foreach (q[i]) begin
      chk({tag, ".busy"}, 32'(busy),      32'(q[i].busy));
      chk({tag, ".done"}, 32'(done),      32'(q[i].done));
      chk({tag, ".rem"},  32'(remaining), 32'(q[i].rem));
      chk({tag, ".cnt"},  32'(cnt),       32'(q[i].cnt));
      chk({tag, ".st"},   32'(st),        32'(q[i].st));
      if (q[i].st) chk({tag, ".X"}, 32'(X), 32'(q[i].x));
      if (inject && q[i].is_run) begin
        start = 1'b1;
        start_addr = 8'($urandom); end_addr = 8'($urandom);
        loops = 8'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      if (i + 1 < q.size()) @(negedge clk);
    end
    start = 1'b0;
    model_cnt = fin;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0; loops = '0;
    cnt_load = 1'b1; cnt_val = 8'd0;
    repeat (2) @(negedge clk);
    cnt_load = 1'b0;
    model_cnt = 8'd0;
    chk("rst_hold.st", 32'(st), 32'd1);
    chk("rst_hold.X",  32'(X),  32'(cnt));
    rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    chk("reset.rem", 32'(remaining), 32'd0);

    do_run("basic_3_5_x2", 8'd3, 8'd5, 8'd2, 1'b0);
    do_run("zero_loops",   8'd40, 8'd60, 8'd0, 1'b0);
    do_run("wrap_254_1",   8'd254, 8'd1, 8'd1, 1'b0);
    do_run("single_7_x3",  8'd7, 8'd7, 8'd3, 1'b0);
    do_run("start_ignored", 8'd9, 8'd12, 8'd2, 1'b1);

    // Reset mid-RUN at cnt=4, with start also high on the reset edge.
    start = 1'b1; start_addr = 8'd2; end_addr = 8'd6; loops = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst.cnt",  32'(cnt),  32'd4);
    chk("midrst.busy", 32'(busy), 32'd1);
    chk("midrst.st_run", 32'(st), 32'd0);
    rst = 1'b1; start = 1'b1; start_addr = 8'd50; end_addr = 8'd55; loops = 8'd5;
    #1;
    chk("midrst.st_in_rst", 32'(st), 32'd1);
    chk("midrst.X_in_rst",  32'(X),  32'd4);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    model_cnt = 8'd4;
    chk_idle("after_rst");
    chk("after_rst.rem", 32'(remaining), 32'd0);
    @(negedge clk);
    chk_idle("after_rst2");
    chk("after_rst2.rem", 32'(remaining), 32'd0);
    do_run("post_rst_run", 8'd20, 8'd22, 8'd2, 1'b0);

    for (int unsigned n = 0; n < 25; n++) begin
      logic [7:0] sa, lp;
      logic [7:0] ea;
      sa = 8'($urandom_range(0, 255));
      ea = 8'(sa + 8'($urandom_range(0, 15)));
      lp = 8'($urandom_range(0, 4));
      do_run("random", sa, ea, lp, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
